// File: rtl/frame_config_writer_if.sv
`default_nettype none
// ============================================================================
// Module      : frame_config_writer_if
// Description : Valid/ready word stream carrying the configuration bitstream
//               into frame_config_writer.
// Revision    : 1.0 - initial release
// ============================================================================
interface frame_config_writer_if;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface
`default_nettype wire

// File: rtl/frame_config_writer.sv
`default_nettype none
// ============================================================================
// Module      : frame_config_writer
// Description : Bitstream-driven configuration frame writer. Waits for a sync
//               word, decodes burst headers, registers each data word into
//               FrameData and pulses a one-hot FrameStrobe for one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_config_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumColumns      = 16
) (
  input  wire logic                          CLK,
  input  wire logic                          resetn,
  frame_config_writer_if.slave               bus,
  output logic [FrameBitsPerRow-1:0]         FrameData,
  output logic [$clog2(NumColumns)-1:0]      FrameCol,
  output logic [MaxFramesPerCol-1:0]         FrameStrobe,
  output logic                               active,
  output logic                               error
);

  localparam int          COL_W       = $clog2(NumColumns);
  localparam int          PTR_W       = $clog2(MaxFramesPerCol);
  localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
  localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HDR    = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PTR_W-1:0]   frame_ptr;
  logic [7:0]         count;      // frames still to write after the current one

  logic               xfer;
  logic               is_sync;
  logic               is_desync;
  logic [3:0]         hdr_op;
  logic [4:0]         hdr_col;
  logic [4:0]         hdr_start;
  logic               hdr_ok;
  logic               ptr_last;

  // Handshake and header field decode
  always_comb begin
    bus.s_ready = resetn && (state != STROBE);
    xfer        = bus.s_valid && bus.s_ready;
    is_sync     = (bus.s_data == SYNC_WORD);
    is_desync   = (bus.s_data == DESYNC_WORD);
    hdr_op      = bus.s_data[31:28];
    hdr_col     = bus.s_data[20:16];
    hdr_start   = bus.s_data[12:8];
    hdr_ok      = (hdr_op == 4'h1) &&
                  (32'(hdr_col) < NumColumns) &&
                  (32'(hdr_start) < MaxFramesPerCol);
    // Advancing past the last frame of the column is a burst overrun
    ptr_last    = (32'(frame_ptr) + 32'd1) >= MaxFramesPerCol;
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (xfer && is_sync) state_nxt = HDR;
      end
      HDR: begin
        if (xfer) begin
          if (is_desync)    state_nxt = IDLE;
          else if (is_sync) state_nxt = HDR;
          else if (hdr_ok)  state_nxt = DATA;
          else              state_nxt = IDLE;
        end
      end
      DATA: begin
        if (xfer) state_nxt = STROBE;
      end
      STROBE: begin
        if (count == 8'd0)  state_nxt = HDR;
        else if (ptr_last)  state_nxt = IDLE;
        else                state_nxt = DATA;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath, burst counters and sticky error flag
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      FrameData <= '0;
      FrameCol  <= '0;
      frame_ptr <= '0;
      count     <= '0;
      error     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && is_sync) error <= 1'b0;
        end
        HDR: begin
          if (xfer && !is_sync && !is_desync) begin
            if (hdr_ok) begin
              FrameCol  <= COL_W'(hdr_col);
              frame_ptr <= PTR_W'(hdr_start);
              count     <= bus.s_data[7:0];
            end else begin
              error <= 1'b1;
            end
          end
        end
        DATA: begin
          if (xfer) FrameData <= FrameBitsPerRow'(bus.s_data);
        end
        STROBE: begin
          if (count != 8'd0) begin
            if (ptr_last) begin
              error <= 1'b1;
            end else begin
              count     <= count - 8'd1;
              frame_ptr <= frame_ptr + PTR_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Strobe decode and activity flag, both derived from the current state
  always_comb begin
    FrameStrobe = '0;
    if (state == STROBE) FrameStrobe[frame_ptr] = 1'b1;
    active = (state != IDLE);
  end

endmodule
`default_nettype wire
